// File: rtl/nsa_pkg.sv
// Shared definitions for the nibble-serial adder sequencer: FSM state type,
// nibble width, and helpers that derive the step count and counter width
// from the operand width.
package nsa_pkg;

    // Width of one adder slice; the shared datapath is always 4 bits wide.
    localparam int NIBBLE_W = 4;

    // Sequencer states.
    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_RUN  = 2'd1,
        ST_DONE = 2'd2
    } state_t;

    // Number of nibble steps needed for a WIDTH-bit operation.
    function automatic int nibble_count(input int width);
        return width / NIBBLE_W;
    endfunction

    // Bits needed to count 0..N-1 nibble steps (never less than one bit).
    function automatic int count_width(input int width);
        int n;
        n = width / NIBBLE_W;
        return (n <= 2) ? 1 : $clog2(n);
    endfunction

endpackage

// File: rtl/four_ripple_carry_adder.sv
// Purely combinational 4-bit ripple carry adder used as the shared nibble
// datapath. Each bit is a full adder; the carry ripples LSB to MSB.
module four_ripple_carry_adder
    import nsa_pkg::*;
(
    input  logic [NIBBLE_W-1:0] a,
    input  logic [NIBBLE_W-1:0] b,
    input  logic                c_in,
    output logic [NIBBLE_W-1:0] sum,
    output logic                c_out
);

    logic [NIBBLE_W:0] carry;

    assign carry[0] = c_in;

    // One full adder per bit, chained through carry[].
    genvar gi;
    generate
        for (gi = 0; gi < NIBBLE_W; gi++) begin : g_full_adder
            assign sum[gi]       = a[gi] ^ b[gi] ^ carry[gi];
            assign carry[gi + 1] = (a[gi] & b[gi]) | (carry[gi] & (a[gi] ^ b[gi]));
        end
    endgenerate

    assign c_out = carry[NIBBLE_W];

endmodule

// File: rtl/nibble_serial_adder_ctrl.sv
// Nibble-serial adder sequencer: performs a WIDTH-bit add over WIDTH/4
// cycles through one shared 4-bit ripple adder, LSB nibble first, with the
// carry registered between steps. Results are held until the next
// completion and announced with a one-cycle done pulse.
//
// Optional feature: define SUB_EN to add a 'sub' input that turns the
// operation into a - b (b inverted, carry-in forced to 1).
//
// WIDTH must be a multiple of 4 and at least 8.
module nibble_serial_adder_ctrl
    import nsa_pkg::*;
#(
    parameter int WIDTH = 16
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             start,
    input  logic [WIDTH-1:0] a,
    input  logic [WIDTH-1:0] b,
    input  logic             c_in,
`ifdef SUB_EN
    input  logic             sub,
`endif
    output logic             busy,
    output logic             done,
    output logic [WIDTH-1:0] sum,
    output logic             c_out,
    output logic             overflow
);

    localparam int N     = nibble_count(WIDTH);
    localparam int CNT_W = count_width(WIDTH);
    localparam logic [CNT_W-1:0] LAST_STEP = CNT_W'(N - 1);

    // Sequencer and output registers.
    state_t           state_reg;
    logic             busy_reg;
    logic             done_reg;
    logic [WIDTH-1:0] sum_reg;
    logic             c_out_reg;
    logic             overflow_reg;

    // Working registers for the operation in flight.
    logic [WIDTH-1:0] a_sh_reg;
    logic [WIDTH-1:0] b_sh_reg;
    logic [WIDTH-1:0] acc_reg;
    logic             carry_reg;
    logic [CNT_W-1:0] cnt_reg;
    logic             a_msb_reg;
    logic             b_msb_reg;

    // Values loaded on acceptance; b/carry differ when subtracting.
    logic [WIDTH-1:0] b_load;
    logic             carry_load;
    logic             accept;

    // Shared nibble datapath outputs.
    logic [NIBBLE_W-1:0] nib_sum;
    logic                nib_c_out;

    // Accumulator after shifting the current nibble result in from the top.
    logic [WIDTH-1:0] acc_next;

`ifdef SUB_EN
    assign b_load     = sub ? ~b : b;
    assign carry_load = sub ? 1'b1 : c_in;
`else
    assign b_load     = b;
    assign carry_load = c_in;
`endif

    // A request is taken in IDLE or in the DONE cycle, never while running.
    assign accept = start && (state_reg != ST_RUN);

    four_ripple_carry_adder u_nibble_adder (
        .a     (a_sh_reg[NIBBLE_W-1:0]),
        .b     (b_sh_reg[NIBBLE_W-1:0]),
        .c_in  (carry_reg),
        .sum   (nib_sum),
        .c_out (nib_c_out)
    );

    // After the last step this holds the complete sum, LSB nibble at bit 0.
    assign acc_next = WIDTH'({nib_sum, acc_reg} >> NIBBLE_W);

    // FSM, nibble-serial datapath and registered outputs.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_reg    <= ST_IDLE;
            busy_reg     <= 1'b0;
            done_reg     <= 1'b0;
            sum_reg      <= '0;
            c_out_reg    <= 1'b0;
            overflow_reg <= 1'b0;
            a_sh_reg     <= '0;
            b_sh_reg     <= '0;
            acc_reg      <= '0;
            carry_reg    <= 1'b0;
            cnt_reg      <= '0;
            a_msb_reg    <= 1'b0;
            b_msb_reg    <= 1'b0;
        end else begin
            done_reg <= 1'b0;
            unique case (state_reg)
                ST_IDLE, ST_DONE: begin
                    if (accept) begin
                        state_reg <= ST_RUN;
                        busy_reg  <= 1'b1;
                        a_sh_reg  <= a;
                        b_sh_reg  <= b_load;
                        acc_reg   <= '0;
                        carry_reg <= carry_load;
                        cnt_reg   <= '0;
                        a_msb_reg <= a[WIDTH-1];
                        b_msb_reg <= b_load[WIDTH-1];
                    end else begin
                        state_reg <= ST_IDLE;
                        busy_reg  <= 1'b0;
                    end
                end
                ST_RUN: begin
                    a_sh_reg  <= a_sh_reg >> NIBBLE_W;
                    b_sh_reg  <= b_sh_reg >> NIBBLE_W;
                    acc_reg   <= acc_next;
                    carry_reg <= nib_c_out;
                    cnt_reg   <= cnt_reg + CNT_W'(1);
                    if (cnt_reg == LAST_STEP) begin
                        state_reg    <= ST_DONE;
                        busy_reg     <= 1'b0;
                        done_reg     <= 1'b1;
                        sum_reg      <= acc_next;
                        c_out_reg    <= nib_c_out;
                        overflow_reg <= (a_msb_reg == b_msb_reg) &&
                                        (nib_sum[NIBBLE_W-1] != a_msb_reg);
                    end
                end
                default: begin
                    state_reg <= ST_IDLE;
                    busy_reg  <= 1'b0;
                end
            endcase
        end
    end

    assign busy     = busy_reg;
    assign done     = done_reg;
    assign sum      = sum_reg;
    assign c_out    = c_out_reg;
    assign overflow = overflow_reg;

endmodule

// File: tb/tb_nibble_serial_adder_ctrl.sv
// Self-checking bench for nibble_serial_adder_ctrl (WIDTH = 16).
module tb_nibble_serial_adder_ctrl;

    localparam int W = 16;
    localparam int N = W / 4;

    logic          clk = 1'b0;
    logic          rst_n = 1'b0;
    logic          start = 1'b0;
    logic [W-1:0]  a = '0;
    logic [W-1:0]  b = '0;
    logic          c_in = 1'b0;
    logic          sub = 1'b0;
    logic          busy;
    logic          done;
    logic [W-1:0]  sum;
    logic          c_out;
    logic          overflow;

    int n_checks = 0;
    int n_fail   = 0;
    logic [W-1:0] last_sum = '0;

    nibble_serial_adder_ctrl #(.WIDTH(W)) dut (
        .clk      (clk),
        .rst_n    (rst_n),
        .start    (start),
        .a        (a),
        .b        (b),
        .c_in     (c_in),
`ifdef SUB_EN
        .sub      (sub),
`endif
        .busy     (busy),
        .done     (done),
        .sum      (sum),
        .c_out    (c_out),
        .overflow (overflow)
    );

    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_checks++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s: observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    // Reference: true integer arithmetic on the full-width values.
    function automatic logic [W+1:0] model(input logic [W-1:0] x, input logic [W-1:0] y,
                                           input logic ci, input logic s);
        logic [W-1:0] yy;
        logic         cc;
        int unsigned  u;
        int           sv;
        logic         ov;
        yy = s ? ~y : y;
        cc = s ? 1'b1 : ci;
        u  = int'(x) + int'(yy) + int'(cc);
        sv = int'($signed(x)) + int'($signed(yy)) + int'(cc);
        ov = (sv > 32767) || (sv < -32768);
        return {ov, u[W], u[W-1:0]};
    endfunction

    // Issue one operation and follow it cycle by cycle to completion.
    task automatic run_op(input logic [W-1:0] ta, input logic [W-1:0] tb_v, input logic tc,
                          input logic [W-1:0] es, input logic ec, input logic eo);
        @(negedge clk);
        a = ta; b = tb_v; c_in = tc; start = 1'b1;
        @(posedge clk);
        #1;
        start = 1'b0;
        check("accept_busy", 32'(busy), 32'd1);
        check("accept_done", 32'(done), 32'd0);
        for (int k = 1; k <= N; k++) begin
            @(posedge clk);
            #1;
            if (k < N) begin
                check("run_busy", 32'(busy), 32'd1);
                check("run_done", 32'(done), 32'd0);
                check("run_sum_held", 32'(sum), 32'(last_sum));
            end else begin
                check("done_pulse", 32'(done), 32'd1);
                check("done_busy", 32'(busy), 32'd0);
                check("sum", 32'(sum), 32'(es));
                check("c_out", 32'(c_out), 32'(ec));
                check("overflow", 32'(overflow), 32'(eo));
            end
        end
        $display("op a=%h b=%h c_in=%0d sub=%0d -> sum=%h c_out=%0d ovf=%0d",
                 ta, tb_v, tc, sub, sum, c_out, overflow);
        last_sum = es;
        @(posedge clk);
        #1;
        check("done_one_cycle", 32'(done), 32'd0);
        check("idle_busy", 32'(busy), 32'd0);
    endtask

    initial begin
        logic [W+1:0] m;
        logic [W-1:0] ra, rb;
        logic         rc;

        // Reset state
        #1;
        check("rst_busy", 32'(busy), 32'd0);
        check("rst_done", 32'(done), 32'd0);
        check("rst_sum", 32'(sum), 32'd0);
        check("rst_c_out", 32'(c_out), 32'd0);
        check("rst_ovf", 32'(overflow), 32'd0);
        repeat (2) @(negedge clk);
        rst_n = 1'b1;

        // Directed cases
        run_op(16'h1234, 16'h4321, 1'b0, 16'h5555, 1'b0, 1'b0);
        run_op(16'hFFFF, 16'h0001, 1'b0, 16'h0000, 1'b1, 1'b0);
        run_op(16'h7FFF, 16'h0001, 1'b0, 16'h8000, 1'b0, 1'b1);
        run_op(16'h0000, 16'h0000, 1'b1, 16'h0001, 1'b0, 1'b0);
        run_op(16'h8000, 16'h8000, 1'b0, 16'h0000, 1'b1, 1'b1);

        // start held through RUN; the start in the DONE cycle is accepted
        @(negedge clk);
        a = 16'h0F0F; b = 16'h0101; c_in = 1'b0; start = 1'b1;
        @(posedge clk);
        #1;
        check("hold_accept_busy", 32'(busy), 32'd1);
        a = 16'h1111; b = 16'h1111;
        for (int k = 1; k <= N; k++) begin
            @(posedge clk);
            #1;
            if (k < N) check("hold_run_busy", 32'(busy), 32'd1);
            else begin
                check("hold_done1", 32'(done), 32'd1);
                check("hold_sum1", 32'(sum), 32'h1010);
            end
        end
        $display("op a=0f0f b=0101 (start held) -> sum=%h", sum);
        @(posedge clk);
        #1;
        start = 1'b0;
        check("b2b_busy", 32'(busy), 32'd1);
        check("b2b_done_low", 32'(done), 32'd0);
        check("b2b_sum_held", 32'(sum), 32'h1010);
        for (int k = 1; k <= N; k++) begin
            @(posedge clk);
            #1;
            if (k < N) check("b2b_run_done", 32'(done), 32'd0);
            else begin
                check("hold_done2", 32'(done), 32'd1);
                check("hold_sum2", 32'(sum), 32'h2222);
            end
        end
        $display("op a=1111 b=1111 (back-to-back) -> sum=%h", sum);
        last_sum = 16'h2222;
        @(posedge clk);
        #1;

        // Asynchronous reset in the middle of an operation
        @(negedge clk);
        a = 16'hAAAA; b = 16'h5555; c_in = 1'b0; start = 1'b1;
        @(posedge clk);
        #1;
        start = 1'b0;
        repeat (2) @(posedge clk);
        #2;
        rst_n = 1'b0;
        #1;
        check("abort_busy", 32'(busy), 32'd0);
        check("abort_done", 32'(done), 32'd0);
        check("abort_sum", 32'(sum), 32'd0);
        check("abort_c_out", 32'(c_out), 32'd0);
        check("abort_ovf", 32'(overflow), 32'd0);
        @(negedge clk);
        rst_n = 1'b1;
        for (int k = 0; k < N + 2; k++) begin
            @(posedge clk);
            #1;
            check("abort_no_done", 32'(done), 32'd0);
        end
        $display("op a=aaaa b=5555 aborted by reset -> sum=%h done=%0d", sum, done);
        last_sum = '0;
        run_op(16'h0003, 16'h0004, 1'b0, 16'h0007, 1'b0, 1'b0);

`ifdef SUB_EN
        sub = 1'b1;
        run_op(16'h0005, 16'h0007, 1'b0, 16'hFFFE, 1'b0, 1'b0);
        run_op(16'h8000, 16'h0001, 1'b1, 16'h7FFF, 1'b1, 1'b1);
        sub = 1'b0;
`endif

        // Randomized operations against the reference model
        for (int i = 0; i < 24; i++) begin
            ra = W'($urandom);
            rb = W'($urandom);
            rc = 1'($urandom_range(0, 1));
`ifdef SUB_EN
            sub = 1'($urandom_range(0, 1));
`endif
            m = model(ra, rb, rc, sub);
            run_op(ra, rb, rc, m[W-1:0], m[W], m[W+1]);
        end

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
